fetch_unit: RTL and testbench

Instruction fetch stage of the five-stage pipeline: owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and drives the fetch-side inputs of the IF/ID pipeline register (pc, inst, pc+4, PC-relative target). It obeys the same `hazard_i` (stall) and `flush_i` (redirect) controls that IF/ID receives, so the two stages stay in lockstep. It presents an all-zero bubble when no instruction is ready.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage; owns the PC, fetches over a req/gnt/rvalid
// handshake and presents pc, inst, pc+4 and the PC-relative target to IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hazard_i,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] pcplus4_o,
    output logic [31:0] pcr_o,
    output logic        fetch_valid_o
);
    typedef enum logic [1:0] {RUN, WAIT, HOLD, KILL} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] redirect;
    logic [31:0] pc_next4;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] target;

    assign redirect = {redirect_pc_i[31:2], 2'b00};
    assign pc_next4 = pc_q + 32'd4;
    assign imm_j    = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
    assign imm_b    = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};

    always_comb begin
        target = pc_q;
        if (inst_q[6:0] == 7'b1101111) target = pc_q + imm_j;
        else if (inst_q[6:0] == 7'b1100011) target = pc_q + imm_b;
    end

    // HOLD requests the following word only when the instruction is consumed
    assign imem_req_o    = (state == RUN) || (state == HOLD && !flush_i && !hazard_i);
    assign imem_addr_o   = (state == HOLD) ? pc_next4 : pc_q;
    assign fetch_valid_o = (state == HOLD);
    assign pc_o          = pc_q;
    assign inst_o        = fetch_valid_o ? inst_q : 32'd0;
    assign pcplus4_o     = fetch_valid_o ? pc_next4 : 32'd0;
    assign pcr_o         = fetch_valid_o ? target : 32'd0;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state  <= RUN;
            pc_q   <= RESET_PC;
            inst_q <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (flush_i) pc_q <= redirect;
                    if (imem_gnt_i) state <= flush_i ? KILL : WAIT;
                end
                WAIT: begin
                    if (flush_i) begin
                        pc_q  <= redirect;
                        state <= imem_rvalid_i ? RUN : KILL;
                    end else if (imem_rvalid_i) begin
                        inst_q <= imem_rdata_i;
                        state  <= HOLD;
                    end
                end
                KILL: begin
                    // a response drains the only outstanding request, so leave even when redirected again
                    if (flush_i) pc_q <= redirect;
                    if (imem_rvalid_i) state <= RUN;
                end
                HOLD: begin
                    if (flush_i) begin
                        pc_q  <= redirect;
                        state <= RUN;
                    end else if (!hazard_i) begin
                        pc_q  <= pc_next4;
                        state <= imem_gnt_i ? WAIT : RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps plus random memory timing, checked against
// a transaction-level model (holding an instruction / request outstanding / response unwanted).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n, hazard, flush, gnt, rvalid;
    logic [31:0] redirect_pc, rdata;
    logic        req, valid;
    logic [31:0] addr, pc, inst, pcplus4, pcr;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_pc = 32'd0, m_inst = 32'd0, m_raddr = 32'd0;
    bit          m_have = 0, m_out = 0, m_disc = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i(clk), .reset_i(reset_n), .hazard_i(hazard), .flush_i(flush),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .pc_o(pc), .inst_o(inst), .pcplus4_o(pcplus4), .pcr_o(pcr), .fetch_valid_o(valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target(input logic [31:0] p, input logic [31:0] i);
        int imm;
        imm = 0;
        if (i[6:0] == 7'h6F)
            imm = (i[31] ? -(1 << 20) : 0) + (int'(i[19:12]) << 12) + (int'(i[20]) << 11) + (int'(i[30:21]) << 1);
        else if (i[6:0] == 7'h63)
            imm = (i[31] ? -4096 : 0) + (int'(i[7]) << 11) + (int'(i[30:25]) << 5) + (int'(i[11:8]) << 1);
        return p + imm;
    endfunction

    function automatic bit exp_req(input bit hz, input bit fl);
        return !m_out && (!m_have || (!fl && !hz));
    endfunction

    task automatic cyc(input bit rst_n, input bit hz, input bit fl, input logic [31:0] rpc,
                       input bit g, input bit rv, input logic [31:0] rd);
        logic [31:0] red;
        bit          er;
        reset_n = rst_n; hazard = hz; flush = fl; redirect_pc = rpc;
        gnt = g; rvalid = rv; rdata = rd;
        #1;
        er = exp_req(hz, fl);
        chk("req", {31'd0, req}, {31'd0, er});
        if (er) chk("addr", addr, m_have ? m_pc + 32'd4 : m_pc);
        chk("valid", {31'd0, valid}, {31'd0, m_have});
        chk("pc", pc, m_pc);
        chk("inst", inst, m_have ? m_inst : 32'd0);
        chk("pcplus4", pcplus4, m_have ? m_pc + 32'd4 : 32'd0);
        chk("pcr", pcr, m_have ? target(m_pc, m_inst) : 32'd0);
        @(posedge clk);
        red = rpc & ~32'd3;
        if (!rst_n) begin
            m_pc = 32'd0; m_inst = 32'd0; m_have = 0; m_out = 0; m_disc = 0;
        end else if (m_have) begin
            if (fl) begin
                m_pc = red; m_have = 0;
            end else if (!hz) begin
                m_pc = m_pc + 32'd4; m_have = 0;
                if (g) begin m_out = 1; m_disc = 0; m_raddr = m_pc; end
            end
        end else if (m_out) begin
            if (fl) m_pc = red;
            if (rv) begin
                m_out = 0;
                if (!m_disc && !fl) begin m_have = 1; m_inst = rd; end
            end else if (fl) m_disc = 1;
        end else begin
            if (fl) m_pc = red;
            if (g) begin m_out = 1; m_disc = fl; m_raddr = m_pc; end
        end
        @(negedge clk);
    endtask

    // zero-wait memory: grant every request, answer the cycle after, data = addr | 13h
    task automatic zw(input bit rst_n, input bit hz, input bit fl, input logic [31:0] rpc);
        cyc(rst_n, hz, fl, rpc, exp_req(hz, fl), m_out, m_raddr | 32'h13);
    endtask

    initial begin
        reset_n = 0; hazard = 0; flush = 0; redirect_pc = 0; gnt = 0; rvalid = 0; rdata = 0;
        @(negedge clk);
        zw(0, 0, 0, 0);
        zw(0, 0, 0, 0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        zw(1, 0, 0, 0);
        zw(1, 0, 0, 0);
        chk("first_valid", {31'd0, valid}, 32'd1);
        chk("first_pc", pc, 32'd0);
        chk("first_pcplus4", pcplus4, 32'd4);
        repeat (4) zw(1, 0, 0, 0);
        chk("pc8", pc, 32'd8);
        repeat (3) zw(1, 1, 0, 0);
        chk("hazard_pc", pc, 32'd8);
        chk("hazard_inst", inst, 32'h1B);
        zw(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h103, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h1234_5678);
        chk("kill_pc", pc, 32'h100);
        chk("kill_valid", {31'd0, valid}, 32'd0);
        zw(1, 0, 0, 0);
        zw(1, 0, 0, 0);
        chk("redirect_pc", pc, 32'h100);
        zw(1, 0, 0, 0);
        cyc(1, 0, 1, 32'h200, 0, 1, 32'hDEAD_BEEF);
        chk("flush_rv_valid", {31'd0, valid}, 32'd0);
        chk("flush_rv_addr", addr, 32'h200);
        cyc(1, 0, 1, 32'h40, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'hFE00_0EE3);
        chk("pcr_beq", pcr, 32'h3C);
        cyc(1, 0, 1, 32'h40, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'h0080_006F);
        chk("pcr_jal", pcr, 32'h48);
        zw(1, 0, 1, 32'hFFFF_FFFE);
        zw(1, 0, 0, 0);
        zw(1, 0, 0, 0);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        zw(1, 0, 0, 0);
        zw(1, 0, 0, 0);
        chk("wrapped_pc", pc, 32'd0);
        zw(1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("rst_mid_inst", inst, 32'd0);
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_addr", addr, 32'd0);
        for (int k = 0; k < 3000; k++) begin
            bit          hz, fl, rv;
            logic [31:0] rpc, rd;
            int          op;
            hz  = ($urandom_range(0, 9) < 3);
            fl  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
            rv  = m_out ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) == 0);
            op  = $urandom_range(0, 2);
            rd  = $urandom;
            rd[6:0] = (op == 0) ? 7'h6F : (op == 1) ? 7'h63 : rd[6:0];
            cyc($urandom_range(0, 99) != 0, hz, fl, rpc, exp_req(hz, fl) && $urandom_range(0, 1) == 1, rv, rd);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
